// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT constants and fixed-point helpers
package fft_pkg;

    localparam int WIDTH  = 16;
    localparam int Q_FRAC = WIDTH - 1;

    // Half an LSB of the Q1.(WIDTH-1) product, added before the fraction shift
    localparam logic signed [63:0] ROUND_CONST = 64'sd1 <<< (Q_FRAC - 1);

    // Clamp v to the signed range of a w-bit word
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v, input int w);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (w - 1));
        if (v > max_v) begin
            return max_v;
        end else if (v < min_v) begin
            return min_v;
        end
        return v;
    endfunction

    // Round half-up then arithmetic shift right by sh (sh >= 1)
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] v, input int sh);
        return (v + (64'sd1 <<< (sh - 1))) >>> sh;
    endfunction

endpackage

// File: rtl/cmul_q15_pipe.sv
// rtl/cmul_q15_pipe.sv - two-stage complex multiply by a Q1.(WIDTH-1) twiddle
module cmul_q15_pipe
    import fft_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] x_real,
    input  logic [WIDTH-1:0] x_imag,
    input  logic [WIDTH-1:0] tw_real,
    input  logic [WIDTH-1:0] tw_imag,
    output logic [WIDTH-1:0] t_real,
    output logic [WIDTH-1:0] t_imag,
    output logic             ovf
);

    localparam int PW = 2 * WIDTH;

    logic signed [PW-1:0] p_rr;
    logic signed [PW-1:0] p_ii;
    logic signed [PW-1:0] p_ri;
    logic signed [PW-1:0] p_ir;

    logic signed [63:0] tr_ext;
    logic signed [63:0] ti_ext;
    logic signed [63:0] tr_rnd;
    logic signed [63:0] ti_rnd;
    logic signed [63:0] tr_sat;
    logic signed [63:0] ti_sat;

    // S1: full-precision partial products
    always_ff @(posedge clk) begin
        if (rst) begin
            p_rr <= '0;
            p_ii <= '0;
            p_ri <= '0;
            p_ir <= '0;
        end else if (en) begin
            p_rr <= PW'($signed(x_real)) * PW'($signed(tw_real));
            p_ii <= PW'($signed(x_imag)) * PW'($signed(tw_imag));
            p_ri <= PW'($signed(x_real)) * PW'($signed(tw_imag));
            p_ir <= PW'($signed(x_imag)) * PW'($signed(tw_real));
        end
    end

    // Combine partials exactly (wide enough for 2*WIDTH+1), round to Q0, saturate
    always_comb begin
        tr_ext = 64'(p_rr) - 64'(p_ii);
        ti_ext = 64'(p_ri) + 64'(p_ir);
        tr_rnd = (tr_ext + ROUND_CONST) >>> Q_FRAC;
        ti_rnd = (ti_ext + ROUND_CONST) >>> Q_FRAC;
        tr_sat = sat_to_width(tr_rnd, WIDTH);
        ti_sat = sat_to_width(ti_rnd, WIDTH);
    end

    // S2: registered rotated operand and its saturation flag
    always_ff @(posedge clk) begin
        if (rst) begin
            t_real <= '0;
            t_imag <= '0;
            ovf    <= 1'b0;
        end else if (en) begin
            t_real <= tr_sat[WIDTH-1:0];
            t_imag <= ti_sat[WIDTH-1:0];
            ovf    <= (tr_sat != tr_rnd) || (ti_sat != ti_rnd);
        end
    end

endmodule

// File: rtl/butterfly_radix2_dit.sv
// rtl/butterfly_radix2_dit.sv - pipelined radix-2 DIT butterfly with valid/ready
module butterfly_radix2_dit
    import fft_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x0_real,
    input  logic [WIDTH-1:0] x0_imag,
    input  logic [WIDTH-1:0] x1_real,
    input  logic [WIDTH-1:0] x1_imag,
    input  logic [WIDTH-1:0] tw_real,
    input  logic [WIDTH-1:0] tw_imag,
    input  logic             scale,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y0_real,
    output logic [WIDTH-1:0] y0_imag,
    output logic [WIDTH-1:0] y1_real,
    output logic [WIDTH-1:0] y1_imag,
    output logic             ovf_sticky,
    input  logic             ovf_clr
);

    logic             adv;
    logic             v1;
    logic             v2;
    logic [WIDTH-1:0] x0r_1;
    logic [WIDTH-1:0] x0i_1;
    logic [WIDTH-1:0] x0r_2;
    logic [WIDTH-1:0] x0i_2;
    logic             sc_1;
    logic             sc_2;
    logic [WIDTH-1:0] t_real;
    logic [WIDTH-1:0] t_imag;
    logic             mul_ovf;
    logic [WIDTH:0]   s_r;
    logic [WIDTH:0]   s_i;
    logic [WIDTH:0]   d_r;
    logic [WIDTH:0]   d_i;
    logic             ovf_event;

    // Whole pipe moves in lockstep; bubbles are kept, not squeezed out
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    cmul_q15_pipe u_cmul (
        .clk     (clk),
        .rst     (rst),
        .en      (adv),
        .x_real  (x1_real),
        .x_imag  (x1_imag),
        .tw_real (tw_real),
        .tw_imag (tw_imag),
        .t_real  (t_real),
        .t_imag  (t_imag),
        .ovf     (mul_ovf)
    );

    // Stage valids plus x0/scale delayed to line up with the multiplier output
    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            x0r_1     <= '0;
            x0i_1     <= '0;
            x0r_2     <= '0;
            x0i_2     <= '0;
            sc_1      <= 1'b0;
            sc_2      <= 1'b0;
        end else if (adv) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
            x0r_1     <= x0_real;
            x0i_1     <= x0_imag;
            x0r_2     <= x0r_1;
            x0i_2     <= x0i_1;
            sc_1      <= scale;
            sc_2      <= sc_1;
        end
    end

    // One S3 lane: optional rounded halving, else saturation; returns {ovf, value}
    function automatic logic [WIDTH:0] s3_lane(input logic signed [63:0] v, input logic sc);
        logic signed [63:0] pre;
        logic signed [63:0] sat;
        pre = sc ? round_shift(v, 1) : v;
        sat = sat_to_width(pre, WIDTH);
        return {sat != pre, sat[WIDTH-1:0]};
    endfunction

    // S3 add/subtract; a halved result always fits so its flag stays low
    always_comb begin
        s_r = s3_lane(64'($signed(x0r_2)) + 64'($signed(t_real)), sc_2);
        s_i = s3_lane(64'($signed(x0i_2)) + 64'($signed(t_imag)), sc_2);
        d_r = s3_lane(64'($signed(x0r_2)) - 64'($signed(t_real)), sc_2);
        d_i = s3_lane(64'($signed(x0i_2)) - 64'($signed(t_imag)), sc_2);
        ovf_event = v2 && (mul_ovf || s_r[WIDTH] || s_i[WIDTH] || d_r[WIDTH] || d_i[WIDTH]);
    end

    // Output register, loaded only by a real beat leaving S2
    always_ff @(posedge clk) begin
        if (rst) begin
            y0_real <= '0;
            y0_imag <= '0;
            y1_real <= '0;
            y1_imag <= '0;
        end else if (adv && v2) begin
            y0_real <= s_r[WIDTH-1:0];
            y0_imag <= s_i[WIDTH-1:0];
            y1_real <= d_r[WIDTH-1:0];
            y1_imag <= d_i[WIDTH-1:0];
        end
    end

    // Sticky overflow: a new event beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (adv && ovf_event) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_butterfly_radix2_dit.sv
// tb/tb_butterfly_radix2_dit.sv - self-checking bench for butterfly_radix2_dit
module tb_butterfly_radix2_dit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x0_real, x0_imag, x1_real, x1_imag, tw_real, tw_imag;
    logic        scale;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y0_real, y0_imag, y1_real, y1_imag;
    logic        ovf_sticky;
    logic        ovf_clr;

    int tests_run = 0;
    int fails     = 0;

    always #5 clk = ~clk;

    butterfly_radix2_dit dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x0_real    (x0_real),
        .x0_imag    (x0_imag),
        .x1_real    (x1_real),
        .x1_imag    (x1_imag),
        .tw_real    (tw_real),
        .tw_imag    (tw_imag),
        .scale      (scale),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y0_real    (y0_real),
        .y0_imag    (y0_imag),
        .y1_real    (y1_real),
        .y1_imag    (y1_imag),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic longint sx(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    // Reference butterfly in plain integer arithmetic; returns {ovf, y0r, y0i, y1r, y1i}
    function automatic logic [64:0] model(input logic [15:0] a0r, a0i, a1r, a1i, wr, wi,
                                          input logic sc);
        longint t[2];
        longint a0[2];
        longint r[4];
        longint v;
        logic   ov;
        ov = 1'b0;
        t[0]  = sx(a1r) * sx(wr) - sx(a1i) * sx(wi);
        t[1]  = sx(a1r) * sx(wi) + sx(a1i) * sx(wr);
        a0[0] = sx(a0r);
        a0[1] = sx(a0i);
        for (int i = 0; i < 2; i++) begin
            t[i] = (t[i] + 16384) >>> 15;
            if (t[i] > 32767) begin t[i] = 32767; ov = 1'b1; end
            if (t[i] < -32768) begin t[i] = -32768; ov = 1'b1; end
        end
        for (int i = 0; i < 4; i++) begin
            v = (i < 2) ? a0[i % 2] + t[i % 2] : a0[i % 2] - t[i % 2];
            if (sc) begin
                v = (v + 1) >>> 1;
            end else begin
                if (v > 32767) begin v = 32767; ov = 1'b1; end
                if (v < -32768) begin v = -32768; ov = 1'b1; end
            end
            r[i] = v;
        end
        return {ov, r[0][15:0], r[1][15:0], r[2][15:0], r[3][15:0]};
    endfunction

    logic [64:0] exp_q[$];
    logic [64:0] e;
    logic [63:0] prev_y;
    logic        prev_stall = 1'b0;
    int          delivered = 0;
    int          stall_cycles = 0;
    logic [63:0] y_now;
    assign y_now = {y0_real, y0_imag, y1_real, y1_imag};

    // Compare process: model scoreboard, handshake rule and stall stability
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            check("in_ready_rule", 80'(in_ready), 80'(!out_valid || out_ready));
            if (prev_stall) begin
                check("stall_hold", {15'd0, out_valid, y_now}, {15'd0, 1'b1, prev_y});
                stall_cycles++;
            end
            if (out_valid && out_ready) begin
                check("beat_expected", 80'(exp_q.size() != 0), 80'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("y_model", 80'(y_now), 80'(e[63:0]));
                    if (e[64]) check("sticky_on_ovf", 80'(ovf_sticky), 80'd1);
                    delivered++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_y     = y_now;
            if (in_valid && in_ready)
                exp_q.push_back(model(x0_real, x0_imag, x1_real, x1_imag, tw_real, tw_imag, scale));
        end
    end

    task automatic set_beat(input int a0r, a0i, a1r, a1i, wr, wi, input logic sc);
        x0_real = 16'(a0r); x0_imag = 16'(a0i);
        x1_real = 16'(a1r); x1_imag = 16'(a1i);
        tw_real = 16'(wr);  tw_imag = 16'(wi);
        scale   = sc;
    endtask

    // One isolated beat with out_ready high; optional ovf_clr in cycle clr_at
    task automatic run_beat(input string name, input int a0r, a0i, a1r, a1i, wr, wi,
                            input logic sc, input int clr_at,
                            input int e0r, e0i, e1r, e1i, input logic e_st);
        int k;
        set_beat(a0r, a0i, a1r, a1i, wr, wi, sc);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        ovf_clr   = (clr_at == 0);
        k = 0;
        while (k < 8) begin
            @(posedge clk); #1;
            k++;
            in_valid = 1'b0;
            ovf_clr  = (k == clr_at);
            if (out_valid) break;
        end
        check({name, " latency"}, 80'(k), 80'd3);
        check({name, " y"}, 80'(y_now), 80'({16'(e0r), 16'(e0i), 16'(e1r), 16'(e1i)}));
        check({name, " sticky"}, 80'(ovf_sticky), 80'(e_st));
    endtask

    task automatic pulse_clr();
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        check("clr_sticky", 80'(ovf_sticky), 80'd0);
    endtask

    int   d0;
    int   guard;
    logic acc;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        set_beat(0, 0, 0, 0, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset out_valid", 80'(out_valid), 80'd0);
        check("reset y", 80'(y_now), 80'd0);
        check("reset sticky", 80'(ovf_sticky), 80'd0);
        check("reset in_ready", 80'(in_ready), 80'd1);

        run_beat("identity", 100, -50, 1000, 0, 32767, 0, 1'b0, -1, 1100, -50, -900, -50, 1'b0);
        run_beat("minus_j", 0, 0, 0, 1000, 0, -32768, 1'b0, -1, 1000, 0, -1000, 0, 1'b0);
        run_beat("add_sat", 30000, 0, 10000, 0, 32767, 0, 1'b0, -1, 32767, 0, 20000, 0, 1'b1);
        pulse_clr();
        run_beat("add_scaled", 30000, 0, 10000, 0, 32767, 0, 1'b1, -1, 20000, 0, 10000, 0, 1'b0);
        run_beat("mul_sat", 0, 0, -32768, -32768, -32768, -32768, 1'b0, 2, 0, 32767, 0, -32767, 1'b1);
        pulse_clr();

        // Backpressure: 8 back-to-back beats, out_ready low for 5 cycles mid-stream
        repeat (2) @(posedge clk); #1;
        d0 = delivered;
        stall_cycles = 0;
        fork
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    set_beat(i * 3001 - 12000, 7000 - i * 1777, i * 4099 - 16000, -i * 2500,
                             (i % 2) ? 23170 : -32768, (i % 3) ? -23170 : 12540, 1'(i % 2));
                    in_valid = 1'b1;
                    acc = 1'b0;
                    guard = 0;
                    while (!acc && guard < 50) begin
                        @(posedge clk);
                        acc = in_ready;
                        #1;
                        guard++;
                    end
                    check("bp input accepted", 80'(acc), 80'd1);
                end
                in_valid = 1'b0;
            end
        join
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        check("bp drained", 80'(exp_q.size()), 80'd0);
        check("bp delivered", 80'(delivered - d0), 80'd8);
        check("bp stall cycles", 80'(stall_cycles), 80'd5);

        // Reset with 3 beats in flight; the first one has already raised the sticky flag
        set_beat(30000, 0, 10000, 0, 32767, 0, 1'b0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        set_beat(1, 2, 3, 4, 5, 6, 1'b0);
        @(posedge clk); #1;
        set_beat(-7, 8, -9, 10, 11, 12, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pre-reset sticky", 80'(ovf_sticky), 80'd1);
        rst = 1'b1;
        d0 = delivered;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst out_valid", 80'(out_valid), 80'd0);
        check("midrst y", 80'(y_now), 80'd0);
        check("midrst sticky", 80'(ovf_sticky), 80'd0);
        repeat (8) @(posedge clk);
        #1;
        check("midrst no stale", 80'(delivered - d0), 80'd0);
        check("midrst out_valid idle", 80'(out_valid), 80'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
